dac_i2c_responder: RTL
======================

# dac_i2c_responder

I2C target that receives the 400 kHz write traffic produced by the design's DAC controller and recovers the 12-bit DAC code and power-down bits, in the same way an MCP4725-class DAC would. It sits on the GPIO_0 DAC I2C lines, either in simulation as the bus-functional DAC model or on-chip as a loopback monitor. It presents the decoded sample to the sequencer design so the bench can check sample values.

## Interface
- ADDR_HI, 6'b110000: upper six bits of the 7-bit target address.
- SYNC_STAGES, 2: synchroniser depth on scl_i and sda_i; must be at least 2.
- Clock  in  1  system clock, 50 MHz.
- nReset  in  1  asynchronous, active-low reset.
- scl_i  in  1  bus SCL level.
- sda_i  in  1  bus SDA level.
- addr_a0  in  1  address LSB strap; the full address is {ADDR_HI, addr_a0}.
- sda_o  out  1  SDA drive value; constant 0.
- sda_t  out  1  SDA tristate; 1 releases the line, 0 pulls it low. Pad logic is `SDA = sda_t ? z : sda_o`.
- dac_value  out  12  last committed DAC code.
- pd_mode  out  2  last committed power-down bits.
- update  out  1  one-cycle pulse when dac_value/pd_mode commit.
- busy  out  1  high from START to STOP while this target is addressed.
- nack_seen  out  1  sticky flag: a transaction was NACKed. Cleared only by reset.

## Operation
- Both inputs pass through SYNC_STAGES flops. All detection uses the synchronised values: scl_s, sda_s, and their one-cycle-delayed copies.
- START is sda_s falling while scl_s is high; STOP is sda_s rising while scl_s is high. Data bits are sampled on the scl_s rising edge.
- States:
  - IDLE.
  - ADDR: 8 bits.
  - ACK.
  - BYTE0: first byte after the address.
  - FAST_LO: fast-mode low byte.
  - CMD_HI, CMD_LO: write-command data bytes.
  - IGNORE: wait for STOP or START.
- START from any state goes to ADDR, clears the bit counter and discards any partial byte (repeated START). STOP from any state goes to IDLE.
- ADDR: after 8 bits, compare {addr[7:1]} with {ADDR_HI, addr_a0}.
  - Match with R/W=0: ACK, then BYTE0, busy=1.
  - Match with R/W=1 (reads are unsupported) or mismatch: no ACK, set nack_seen, go to IGNORE, busy stays 0.
- BYTE0, decoded on bits [7:6]:
  - 00 is fast mode: pd=b[5:4], hi4=b[3:0]; ACK, then FAST_LO.
  - 01 is a write command: C2C1C0=b[7:5] is 010 or 011 (EEPROM write is treated as DAC-only); pd=b[2:1]; ACK, then CMD_HI.
  - 1x is an unsupported command: NACK, set nack_seen, go to IGNORE.
- FAST_LO: commit dac_value={hi4,b[7:0]} and pd_mode; ACK; return to BYTE0, so consecutive fast-mode pairs are allowed.
- CMD_HI: latch b[7:0] as D11..D4; ACK; go to CMD_LO.
- CMD_LO: commit dac_value={D11..D4, b[7:4]}; ACK; return to BYTE0.
- A commit happens only when a full byte completes. Partial transactions never alter dac_value.
- An ACK is one SCL period (the 9th clock) with sda_t=0. A NACK leaves sda_t=1 throughout.

## Timing
- Reset values: sda_o=0, sda_t=1, dac_value=0, pd_mode=0, update=0, busy=0, nack_seen=0, state IDLE.
- Input latency: SYNC_STAGES+1 Clock cycles from pin edge to detected event.
- ACK drive: sda_t goes to 0 on the cycle after the scl_s falling edge that ends bit 8. It returns to 1 on the cycle after the scl_s falling edge that ends the 9th clock.
- update pulses for exactly 1 cycle, on the cycle after the scl_s rising edge of bit 8 of the committing byte. dac_value and pd_mode are valid from the same cycle.
- busy rises the cycle the address ACK is driven and falls on the cycle STOP is detected.
- If a START or STOP is detected while an ACK is being driven, release immediately: sda_t=1 on the next cycle.
- Asynchronous reset mid-ACK forces sda_t=1 without waiting for a clock.
- Any SDA change while SCL is high that is not a valid START/STOP condition does not occur on a legal bus. It is handled as START/STOP by the detection rules.

## Structure
- Shared package `dac_i2c_pkg` holds:
  - the state enum;
  - MCP_ADDR_HI=6'b110000;
  - command codes CMD_WRITE_DAC=3'b010 and CMD_WRITE_DAC_EE=3'b011;
  - the width constant DAC_W=12.
- Sub-module `i2c_bus_sync` covers the synchronisers and the START/STOP/rise/fall detection. It is reusable by any future I2C target.

## Test plan
- Reset, addr_a0=0: address 0xC0, then 0x0A, 0xBC at 400 kHz, then STOP → three ACKs, dac_value=0xABC, pd_mode=00, one update pulse, busy low after STOP.
- Address byte 0xC2 (0x61, R/W=0) → no ACK, sda_t held 1, nack_seen=1, dac_value unchanged, busy stays 0.
- 0xC0, then 0x01,0x23, 0x34,0x56 → two update pulses; final dac_value=0x456, pd_mode=11.
- 0xC0, then 0x40, 0x80, 0x00 → dac_value=0x800, pd_mode=00; command byte 0xC0 instead of 0x40 → NACK, nack_seen=1.
- Repeated START after 4 bits of the data byte, then a full 0xC0, 0x0F, 0xFF → only one update, dac_value=0xFFF.
- nReset asserted while ACK is driven → sda_t=1 immediately; all outputs return to reset values.

Source files
------------

// File: rtl/dac_i2c_pkg.sv
// Shared types and constants for the MCP4725-style DAC I2C responder.
package dac_i2c_pkg;

  localparam logic [5:0] MCP_ADDR_HI      = 6'b110000;
  localparam logic [2:0] CMD_WRITE_DAC    = 3'b010;
  localparam logic [2:0] CMD_WRITE_DAC_EE = 3'b011;
  localparam int         DAC_W            = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK,
    ST_BYTE0,
    ST_FAST_LO,
    ST_CMD_HI,
    ST_CMD_LO,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the system clock domain and flags SCL edges
// plus START/STOP conditions, for reuse by any I2C target.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // An idle I2C bus is pulled high, so everything resets to 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_s_o    = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/dac_i2c_responder.sv
// I2C write-only target decoding MCP4725 fast-mode and write-DAC commands
// into a 12-bit code plus power-down bits.
module dac_i2c_responder
  import dac_i2c_pkg::*;
#(
  parameter logic [5:0] ADDR_HI     = MCP_ADDR_HI,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             scl_i,
  input  logic             sda_i,
  input  logic             addr_a0,
  output logic             sda_o,
  output logic             sda_t,
  output logic [DAC_W-1:0] dac_value,
  output logic [1:0]       pd_mode,
  output logic             update,
  output logic             busy,
  output logic             nack_seen
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i     (Clock),
    .rst_ni    (nReset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s_o   (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  state_e             state_q;
  state_e             next_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic [3:0]         hi4_q;
  logic [1:0]         pd_pend_q;
  logic [7:0]         dhi_q;
  logic [DAC_W-1:0]   dac_value_q;
  logic [1:0]         pd_mode_q;
  logic               update_q;
  logic               busy_q;
  logic               nack_q;
  logic               sda_t_q;
  logic [7:0]         byte_w;

  assign byte_w = {shift_q[6:0], sda_s};

  // In ST_ACK, sda_t_q doubles as the phase flag: 1 = waiting for the fall
  // ending bit 8, 0 = driving ACK until the fall ending the 9th clock.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      next_q      <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      hi4_q       <= 4'h0;
      pd_pend_q   <= 2'b00;
      dhi_q       <= 8'h00;
      dac_value_q <= '0;
      pd_mode_q   <= 2'b00;
      update_q    <= 1'b0;
      busy_q      <= 1'b0;
      nack_q      <= 1'b0;
      sda_t_q     <= 1'b1;
    end else begin
      update_q <= 1'b0;
      if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= 3'd0;
        shift_q   <= 8'h00;
        sda_t_q   <= 1'b1;
      end else if (stop_det) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        sda_t_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_IGNORE: ;
          ST_ACK: begin
            if (scl_fall) begin
              if (sda_t_q) begin
                sda_t_q <= 1'b0;
                busy_q  <= 1'b1;
              end else begin
                sda_t_q   <= 1'b1;
                state_q   <= next_q;
                bit_cnt_q <= 3'd0;
              end
            end
          end
          default: begin
            if (scl_rise) begin
              shift_q   <= byte_w;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= ST_ACK;
                case (state_q)
                  ST_ADDR: begin
                    if (byte_w[7:1] == {ADDR_HI, addr_a0} && !byte_w[0]) begin
                      next_q <= ST_BYTE0;
                    end else begin
                      state_q <= ST_IGNORE;
                      nack_q  <= 1'b1;
                      busy_q  <= 1'b0;
                    end
                  end
                  ST_BYTE0: begin
                    if (byte_w[7:6] == 2'b00) begin
                      pd_pend_q <= byte_w[5:4];
                      hi4_q     <= byte_w[3:0];
                      next_q    <= ST_FAST_LO;
                    end else if (byte_w[7:5] == CMD_WRITE_DAC ||
                                 byte_w[7:5] == CMD_WRITE_DAC_EE) begin
                      pd_pend_q <= byte_w[2:1];
                      next_q    <= ST_CMD_HI;
                    end else begin
                      state_q <= ST_IGNORE;
                      nack_q  <= 1'b1;
                    end
                  end
                  ST_FAST_LO: begin
                    dac_value_q <= {hi4_q, byte_w};
                    pd_mode_q   <= pd_pend_q;
                    update_q    <= 1'b1;
                    next_q      <= ST_BYTE0;
                  end
                  ST_CMD_HI: begin
                    dhi_q  <= byte_w;
                    next_q <= ST_CMD_LO;
                  end
                  default: begin
                    dac_value_q <= {dhi_q, byte_w[7:4]};
                    pd_mode_q   <= pd_pend_q;
                    update_q    <= 1'b1;
                    next_q      <= ST_BYTE0;
                  end
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  assign sda_o     = 1'b0;
  assign sda_t     = sda_t_q;
  assign dac_value = dac_value_q;
  assign pd_mode   = pd_mode_q;
  assign update    = update_q;
  assign busy      = busy_q;
  assign nack_seen = nack_q;

endmodule
